hazard_arbiter: RTL and testbench
=================================

Name: hazard_arbiter

Overview:
Parametrised successor to the fixed fetch/decode/issue hazard controller. It takes per-stage hazard requests and a prioritised set of PC-redirect requests. From these it resolves per-stage stall/flush controls and a single load-PC command for a NUM_STAGES-deep in-order front end.
It adds two things the fixed controller lacks:
- a multi-cycle misprediction recovery FSM that squashes and freezes the front end while rename/checkpoint state restores;
- per-stage saturating hazard-event counters with edge detection, replacing simulation-only checkpoint logic.

Parameters:
NUM_STAGES, 4, pipeline stages controlled; stage 0 = fetch, ascending = downstream.
NUM_REDIRECT, 2, redirect sources; index 0 = highest priority (oldest/deepest).
PC_W, 32, redirect target width.
RECOVERY_CYCLES, 2, extra squash cycles after a recovering redirect; 0 disables the FSM.
CNT_W, 16, width of each event counter.
STG_W, $clog2(NUM_STAGES+1), width of a flush-depth field.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
stage_hazard_i  in  NUM_STAGES  bit i: stage i cannot advance this cycle
redirect_valid_i  in  NUM_REDIRECT  redirect request per source
redirect_target_i  in  NUM_REDIRECT*PC_W  flattened targets, source r at [r*PC_W +: PC_W]
redirect_depth_i  in  NUM_REDIRECT*STG_W  stages 0..depth-1 squashed by source r; 0 = PC load only
redirect_recover_i  in  NUM_REDIRECT  source r request needs recovery (mispredict)
cnt_clear_i  in  1  synchronous clear of all counters
stall_o  out  NUM_STAGES  stage i holds its register
flush_o  out  NUM_STAGES  register at output of stage i loads a bubble
load_pc_we_o  out  1  overwrite fetch PC
load_pc_o  out  PC_W  new PC
recovering_o  out  1  FSM in RECOVER
redirect_id_o  out  $clog2(NUM_REDIRECT) (min 1)  winning source index, valid with load_pc_we_o
event_cnt_o  out  NUM_STAGES*CNT_W  per-stage hazard event counts
stall_cycle_cnt_o  out  CNT_W  cycles with any stall_o bit set

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-low on rst_n.
- Reset values: all outputs 0, FSM IDLE, counters 0, hazard history 0. Reset mid-recovery aborts to IDLE next cycle.
- Base resolution (combinational, no redirect):
  - stall_o[i] = OR(stage_hazard_i[j]) for j >= i.
  - flush_o[i] = stall_o[i] & ~stall_o[i+1].
  - flush_o[NUM_STAGES-1] = stall_o[NUM_STAGES-1].
- Redirect winner: lowest valid index r; redirect_id_o = r.
  - load_pc_we_o = 1 and load_pc_o = target[r], same cycle.
  - For i < depth[r]: stall_o[i] = 0 and flush_o[i] = 1. This overrides base resolution and any hazard at those stages.
  - Stages >= depth[r] keep base values.
  - Lower-priority sources are ignored that cycle.
- FSM states: IDLE, RECOVER.
  - IDLE -> RECOVER when a winner has recover = 1 and RECOVERY_CYCLES > 0. Latch rec_depth = depth[r], rec_id = r, rec_cnt = RECOVERY_CYCLES.
  - In RECOVER:
    - for i < rec_depth: flush_o[i] = 1, stall_o[i] = 0, except stall_o[0] = 1 (fetch frozen);
    - load_pc_we_o = 0 unless a new winner exists;
    - rec_cnt decrements each cycle;
    - exit to IDLE in the cycle rec_cnt reaches 1 (exactly RECOVERY_CYCLES RECOVER cycles).
  - New winner during RECOVER with index <= rec_id: its redirect acts this cycle (load PC, flush to its depth). If it also has recover = 1, relatch and restart the count; otherwise the FSM continues the old count.
  - New winner with index > rec_id during RECOVER: ignored. No PC load.
- Counters:
  - hz_prev registers stage_hazard_i each cycle.
  - event_cnt[i] increments when stage_hazard_i[i] & ~hz_prev[i].
  - stall_cycle_cnt increments when |stall_o.
  - All counters saturate at 2^CNT_W-1.
  - cnt_clear_i zeroes them and wins over a same-cycle increment.
- All control outputs are combinational from inputs plus FSM state; zero added latency.

Decomposition:
- hazard_pkg:
  - arb_state_e {IDLE, RECOVER};
  - localparam helper for index widths (max(1, clog2));
  - unpack functions for flattened redirect fields.
- Sub-module hazard_event_counter (rising-edge detect + saturating CNT_W counter + clear).
  - Instantiated NUM_STAGES times.
  - A level-mode instance, with edge detect bypassed by a parameter, provides stall_cycle_cnt.

Test Plan (NUM_STAGES=4, NUM_REDIRECT=2, RECOVERY_CYCLES=2, CNT_W=4):
1. stage_hazard_i=4'b0100 steady 3 cycles -> stall_o=0111, flush_o=0100 each cycle; event_cnt[2]=1; stall_cycle_cnt=3.
2. Source 1 valid, depth=2, target 0x400, recover=0, with stage_hazard_i=0001 -> load_pc_we_o=1, load_pc_o=0x400, redirect_id_o=1, stall_o=0000, flush_o=0011; FSM stays IDLE.
3. Sources 0 and 1 valid together, source 0 depth=3, recover=1, target 0x80 -> load_pc_o=0x80, flush_o=0111. Next 2 cycles: recovering_o=1, stall_o[0]=1, flush_o=0111. Then IDLE.
4. During RECOVER, source 1 redirect -> ignored, load_pc_we_o=0. Source 0 recover redirect on 2nd RECOVER cycle -> PC loaded, count restarts, 2 further RECOVER cycles.
5. Toggle stage_hazard_i[3] 20 times -> event_cnt[3]=15 (saturated). cnt_clear_i together with a new edge -> 0.
6. rst_n=0 on 1st RECOVER cycle -> next cycle recovering_o=0, all outputs and counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard arbiter.
// Contents:
//   arb_state_e  - recovery FSM states
//   idx_w()      - index width helper, never narrower than one bit
//   unpack_field - extracts field idx of a flattened multi-source bus
package hazard_pkg;

  typedef enum logic {
    StIdle    = 1'b0,
    StRecover = 1'b1
  } arb_state_e;

  // Upper bounds for the generic unpack helper; callers size-cast in and out.
  localparam int unsigned MaxFlatW  = 1024;
  localparam int unsigned MaxFieldW = 64;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MaxFieldW-1:0] unpack_field(input logic [MaxFlatW-1:0] flat,
                                                        input int unsigned       idx,
                                                        input int unsigned       width);
    logic [MaxFlatW-1:0] mask;
    mask = (width >= MaxFlatW) ? '1 : ((MaxFlatW'(1) << width) - MaxFlatW'(1));
    return MaxFieldW'((flat >> (idx * width)) & mask);
  endfunction

endpackage

// File: rtl/hazard_arbiter_if.sv
// Bundles the hazard arbiter's request inputs and control/counter outputs.
// Signal suffixes are from the arbiter's point of view.
//   master : requester / observer side (drives *_i, reads *_o)
//   slave  : the arbiter itself
interface hazard_arbiter_if
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned NUM_REDIRECT    = 2,
  parameter int unsigned PC_W            = 32,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned STG_W           = $clog2(NUM_STAGES + 1)
) ();
  localparam int unsigned IdW = idx_w(NUM_REDIRECT);

  logic [NUM_STAGES-1:0]         stage_hazard_i;
  logic [NUM_REDIRECT-1:0]       redirect_valid_i;
  logic [NUM_REDIRECT*PC_W-1:0]  redirect_target_i;
  logic [NUM_REDIRECT*STG_W-1:0] redirect_depth_i;
  logic [NUM_REDIRECT-1:0]       redirect_recover_i;
  logic                          cnt_clear_i;
  logic [NUM_STAGES-1:0]         stall_o;
  logic [NUM_STAGES-1:0]         flush_o;
  logic                          load_pc_we_o;
  logic [PC_W-1:0]               load_pc_o;
  logic                          recovering_o;
  logic [IdW-1:0]                redirect_id_o;
  logic [NUM_STAGES*CNT_W-1:0]   event_cnt_o;
  logic [CNT_W-1:0]              stall_cycle_cnt_o;

  modport master (
    output stage_hazard_i, redirect_valid_i, redirect_target_i, redirect_depth_i,
           redirect_recover_i, cnt_clear_i,
    input  stall_o, flush_o, load_pc_we_o, load_pc_o, recovering_o, redirect_id_o,
           event_cnt_o, stall_cycle_cnt_o
  );

  modport slave (
    input  stage_hazard_i, redirect_valid_i, redirect_target_i, redirect_depth_i,
           redirect_recover_i, cnt_clear_i,
    output stall_o, flush_o, load_pc_we_o, load_pc_o, recovering_o, redirect_id_o,
           event_cnt_o, stall_cycle_cnt_o
  );
endinterface

// File: rtl/hazard_event_counter.sv
// Saturating event counter with optional rising-edge detection.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_level    : event source level
//   i_clear    : synchronous clear, wins over a same-cycle increment
//   o_count    : current count, saturates at all-ones
// EDGE_MODE=1 counts 0->1 transitions of i_level; EDGE_MODE=0 counts high cycles.
module hazard_event_counter #(
  parameter int unsigned CNT_W     = 16,
  parameter bit          EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_level,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count
);
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;

  assign w_inc = EDGE_MODE ? (i_level & ~r_prev) : i_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_level;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (w_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_count = r_cnt;
endmodule

// File: rtl/hazard_arbiter.sv
// Front-end hazard arbiter: resolves per-stage stall/flush, picks one PC redirect,
// runs a multi-cycle misprediction recovery FSM and keeps hazard event counters.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : hazard_arbiter_if.slave (requests in, controls and counters out)
// All control outputs are combinational from inputs and FSM state.
module hazard_arbiter
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned NUM_REDIRECT    = 2,
  parameter int unsigned PC_W            = 32,
  parameter int unsigned RECOVERY_CYCLES = 2,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned STG_W           = $clog2(NUM_STAGES + 1)
) (
  input logic             clk,
  input logic             rst_n,
  hazard_arbiter_if.slave bus
);
  localparam int unsigned IdW = idx_w(NUM_REDIRECT);
  localparam int unsigned RcW = idx_w(RECOVERY_CYCLES + 1);

  arb_state_e       r_state, w_state;
  logic [STG_W-1:0] r_rec_depth, w_rec_depth;
  logic [IdW-1:0]   r_rec_id, w_rec_id;
  logic [RcW-1:0]   r_rec_cnt, w_rec_cnt;

  logic [PC_W-1:0]  w_tgt   [NUM_REDIRECT];
  logic [STG_W-1:0] w_depth [NUM_REDIRECT];

  logic             w_win_valid;
  logic [IdW-1:0]   w_win_id;
  logic [STG_W-1:0] w_win_depth;
  logic [PC_W-1:0]  w_win_tgt;
  logic             w_win_rec;
  logic             w_start;

  logic [NUM_STAGES-1:0] w_stall, w_flush;
  logic                  w_any;
  logic [CNT_W-1:0]      w_evt_cnt [NUM_STAGES];
  logic [CNT_W-1:0]      w_stall_cyc;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REDIRECT; r++) begin
      w_tgt[r]   = PC_W'(unpack_field(MaxFlatW'(bus.redirect_target_i), r, PC_W));
      w_depth[r] = STG_W'(unpack_field(MaxFlatW'(bus.redirect_depth_i), r, STG_W));
    end
  end

  // Lowest valid index wins; while recovering only sources at or above the
  // recovering one's priority are eligible.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    for (int unsigned r = 0; r < NUM_REDIRECT; r++) begin
      if (!w_win_valid && bus.redirect_valid_i[r] &&
          ((r_state == StIdle) || (IdW'(r) <= r_rec_id))) begin
        w_win_valid = 1'b1;
        w_win_id    = IdW'(r);
      end
    end
    w_win_depth = w_depth[w_win_id];
    w_win_tgt   = w_tgt[w_win_id];
    w_win_rec   = bus.redirect_recover_i[w_win_id];
  end

  assign w_start = w_win_valid && w_win_rec && (RECOVERY_CYCLES > 0);

  always_comb begin
    w_stall = '0;
    w_flush = '0;
    w_any   = 1'b0;
    // A hazard at stage j backs up every stage upstream of it.
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      w_any      = w_any | bus.stage_hazard_i[i];
      w_stall[i] = w_any;
    end
    for (int unsigned i = 0; i + 1 < NUM_STAGES; i++) begin
      w_flush[i] = w_stall[i] & ~w_stall[i+1];
    end
    w_flush[NUM_STAGES-1] = w_stall[NUM_STAGES-1];

    if (r_state == StRecover) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (STG_W'(i) < r_rec_depth) begin
          w_flush[i] = 1'b1;
          w_stall[i] = 1'b0;
        end
      end
      if (r_rec_depth != '0) w_stall[0] = 1'b1;  // fetch frozen during restore
    end

    if (w_win_valid) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (STG_W'(i) < w_win_depth) begin
          w_flush[i] = 1'b1;
          w_stall[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_rec_depth = r_rec_depth;
    w_rec_id    = r_rec_id;
    w_rec_cnt   = r_rec_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state     = StRecover;
          w_rec_depth = w_win_depth;
          w_rec_id    = w_win_id;
          w_rec_cnt   = RcW'(RECOVERY_CYCLES);
        end
      end
      StRecover: begin
        if (w_start) begin
          w_rec_depth = w_win_depth;
          w_rec_id    = w_win_id;
          w_rec_cnt   = RcW'(RECOVERY_CYCLES);
        end else if (r_rec_cnt <= RcW'(1)) begin
          w_state = StIdle;
        end else begin
          w_rec_cnt = r_rec_cnt - RcW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_rec_depth <= '0;
      r_rec_id    <= '0;
      r_rec_cnt   <= '0;
    end else begin
      r_state     <= w_state;
      r_rec_depth <= w_rec_depth;
      r_rec_id    <= w_rec_id;
      r_rec_cnt   <= w_rec_cnt;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_evt
    hazard_event_counter #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (1'b1)
    ) u_evt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_level (bus.stage_hazard_i[g]),
      .i_clear (bus.cnt_clear_i),
      .o_count (w_evt_cnt[g])
    );
  end

  hazard_event_counter #(
    .CNT_W     (CNT_W),
    .EDGE_MODE (1'b0)
  ) u_stall_cyc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (|w_stall),
    .i_clear (bus.cnt_clear_i),
    .o_count (w_stall_cyc)
  );

  always_comb begin
    bus.event_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      bus.event_cnt_o[i*CNT_W +: CNT_W] = w_evt_cnt[i];
    end
  end

  assign bus.stall_o           = w_stall;
  assign bus.flush_o           = w_flush;
  assign bus.load_pc_we_o      = w_win_valid;
  assign bus.load_pc_o         = w_win_valid ? w_win_tgt : '0;
  assign bus.redirect_id_o     = w_win_valid ? w_win_id : '0;
  assign bus.recovering_o      = (r_state == StRecover);
  assign bus.stall_cycle_cnt_o = w_stall_cyc;
endmodule

// File: tb/tb_hazard_arbiter.sv
// Directed bench for hazard_arbiter with a cycle-level reference model.
module tb_hazard_arbiter;
  localparam int NS = 4;
  localparam int NR = 2;
  localparam int PW = 32;
  localparam int RC = 2;
  localparam int CW = 4;
  localparam int SW = 3;
  localparam int CMAX = 15;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hazard_arbiter_if #(
    .NUM_STAGES   (NS),
    .NUM_REDIRECT (NR),
    .PC_W         (PW),
    .CNT_W        (CW),
    .STG_W        (SW)
  ) bus ();

  hazard_arbiter #(
    .NUM_STAGES      (NS),
    .NUM_REDIRECT    (NR),
    .PC_W            (PW),
    .RECOVERY_CYCLES (RC),
    .CNT_W           (CW),
    .STG_W           (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] hz, input logic [1:0] v, input logic [31:0] t0,
                        input logic [31:0] t1, input logic [2:0] d0, input logic [2:0] d1,
                        input logic [1:0] rc, input logic clr);
    bus.stage_hazard_i     = hz;
    bus.redirect_valid_i   = v;
    bus.redirect_target_i  = {t1, t0};
    bus.redirect_depth_i   = {d1, d0};
    bus.redirect_recover_i = rc;
    bus.cnt_clear_i        = clr;
  endtask

  task automatic idle();
    set_in(4'b0, 2'b0, 32'h0, 32'h0, 3'd0, 3'd0, 2'b0, 1'b0);
  endtask

  // Reference model state: what the arbiter must hold after the last clock edge.
  bit m_rec;
  int m_rec_depth, m_rec_id, m_rec_left;
  bit [NS-1:0] m_prev;
  int m_evt[NS];
  int m_sc;

  initial begin : compare
    bit [NS-1:0] hz, e_stall, e_flush;
    int win, dep;
    m_rec = 0; m_rec_depth = 0; m_rec_id = 0; m_rec_left = 0;
    m_prev = '0; m_sc = 0;
    for (int i = 0; i < NS; i++) m_evt[i] = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      hz = bus.stage_hazard_i;
      for (int i = 0; i < NS; i++) begin
        e_stall[i] = 1'b0;
        for (int j = i; j < NS; j++) if (hz[j]) e_stall[i] = 1'b1;
      end
      for (int i = 0; i < NS; i++)
        e_flush[i] = (i == NS - 1) ? e_stall[i] : (e_stall[i] && !e_stall[i+1]);
      if (m_rec) begin
        for (int i = 0; i < m_rec_depth && i < NS; i++) begin
          e_flush[i] = 1'b1;
          e_stall[i] = 1'b0;
        end
        if (m_rec_depth > 0) e_stall[0] = 1'b1;
      end
      win = -1;
      for (int r = NR - 1; r >= 0; r--) if (bus.redirect_valid_i[r]) win = r;
      if (m_rec && win > m_rec_id) win = -1;
      if (win >= 0) begin
        dep = int'(bus.redirect_depth_i[win*SW +: SW]);
        for (int i = 0; i < dep && i < NS; i++) begin
          e_flush[i] = 1'b1;
          e_stall[i] = 1'b0;
        end
      end

      chk("m_stall", bus.stall_o, e_stall);
      chk("m_flush", bus.flush_o, e_flush);
      chk("m_we", bus.load_pc_we_o, (win >= 0));
      chk("m_recovering", bus.recovering_o, m_rec);
      if (win >= 0) begin
        chk("m_pc", bus.load_pc_o, bus.redirect_target_i[win*PW +: PW]);
        chk("m_id", bus.redirect_id_o, win);
      end
      for (int i = 0; i < NS; i++) chk("m_evt", bus.event_cnt_o[i*CW +: CW], m_evt[i]);
      chk("m_stall_cyc", bus.stall_cycle_cnt_o, m_sc);

      if (!rst_n) begin
        m_rec = 0; m_rec_depth = 0; m_rec_id = 0; m_rec_left = 0;
        m_prev = '0; m_sc = 0;
        for (int i = 0; i < NS; i++) m_evt[i] = 0;
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (bus.cnt_clear_i) m_evt[i] = 0;
          else if (hz[i] && !m_prev[i] && m_evt[i] < CMAX) m_evt[i]++;
        end
        m_prev = hz;
        if (bus.cnt_clear_i) m_sc = 0;
        else if (|e_stall && m_sc < CMAX) m_sc++;
        if (win >= 0 && bus.redirect_recover_i[win] && RC > 0) begin
          m_rec = 1; m_rec_depth = dep; m_rec_id = win; m_rec_left = RC;
        end else if (m_rec) begin
          m_rec_left--;
          if (m_rec_left == 0) m_rec = 0;
        end
      end
    end
  end

  initial begin : stim
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall", bus.stall_o, 4'b0);
    chk("rst_recovering", bus.recovering_o, 1'b0);
    chk("rst_evt", bus.event_cnt_o, 16'h0);
    chk("rst_stall_cyc", bus.stall_cycle_cnt_o, 4'd0);
    cyc();

    // Steady hazard at stage 2.
    set_in(4'b0100, 2'b0, 32'h0, 32'h0, 3'd0, 3'd0, 2'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_stall", bus.stall_o, 4'b0111);
      chk("t1_flush", bus.flush_o, 4'b0100);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t1_evt2", bus.event_cnt_o[11:8], 4'd1);
    chk("t1_stall_cyc", bus.stall_cycle_cnt_o, 4'd3);
    cyc();

    // Plain redirect from source 1.
    set_in(4'b0001, 2'b10, 32'h0, 32'h400, 3'd0, 3'd2, 2'b00, 1'b0);
    @(negedge clk);
    chk("t2_we", bus.load_pc_we_o, 1'b1);
    chk("t2_pc", bus.load_pc_o, 32'h400);
    chk("t2_id", bus.redirect_id_o, 1'b1);
    chk("t2_stall", bus.stall_o, 4'b0000);
    chk("t2_flush", bus.flush_o, 4'b0011);
    cyc();
    idle();
    @(negedge clk);
    chk("t2_idle", bus.recovering_o, 1'b0);
    cyc();

    // Two sources, source 0 wins and enters recovery.
    set_in(4'b0, 2'b11, 32'h80, 32'h400, 3'd3, 3'd2, 2'b01, 1'b0);
    @(negedge clk);
    chk("t3_pc", bus.load_pc_o, 32'h80);
    chk("t3_id", bus.redirect_id_o, 1'b0);
    chk("t3_flush", bus.flush_o, 4'b0111);
    cyc();
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3_recovering", bus.recovering_o, 1'b1);
      chk("t3_rec_stall", bus.stall_o, 4'b0001);
      chk("t3_rec_flush", bus.flush_o, 4'b0111);
      cyc();
    end
    @(negedge clk);
    chk("t3_exit", bus.recovering_o, 1'b0);
    chk("t3_exit_flush", bus.flush_o, 4'b0000);
    cyc();

    // Redirects arriving during recovery.
    set_in(4'b0, 2'b01, 32'h100, 32'h0, 3'd2, 3'd0, 2'b01, 1'b0);
    @(negedge clk);
    chk("t4_enter_we", bus.load_pc_we_o, 1'b1);
    cyc();
    set_in(4'b0, 2'b10, 32'h0, 32'h200, 3'd0, 3'd1, 2'b10, 1'b0);
    @(negedge clk);
    chk("t4_ignored_we", bus.load_pc_we_o, 1'b0);
    chk("t4_ignored_flush", bus.flush_o, 4'b0011);
    cyc();
    set_in(4'b0, 2'b01, 32'h300, 32'h0, 3'd3, 3'd0, 2'b01, 1'b0);
    @(negedge clk);
    chk("t4_re_we", bus.load_pc_we_o, 1'b1);
    chk("t4_re_pc", bus.load_pc_o, 32'h300);
    chk("t4_re_stall", bus.stall_o, 4'b0000);
    chk("t4_re_flush", bus.flush_o, 4'b0111);
    cyc();
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_recovering", bus.recovering_o, 1'b1);
      chk("t4_rec_flush", bus.flush_o, 4'b0111);
      cyc();
    end
    @(negedge clk);
    chk("t4_exit", bus.recovering_o, 1'b0);
    cyc();

    // Saturation, then clear colliding with a new edge.
    for (int k = 0; k < 20; k++) begin
      set_in(4'b1000, 2'b0, 32'h0, 32'h0, 3'd0, 3'd0, 2'b0, 1'b0);
      cyc();
      idle();
      cyc();
    end
    @(negedge clk);
    chk("t5_evt3_sat", bus.event_cnt_o[15:12], 4'd15);
    chk("t5_stall_cyc_sat", bus.stall_cycle_cnt_o, 4'd15);
    cyc();
    set_in(4'b1000, 2'b0, 32'h0, 32'h0, 3'd0, 3'd0, 2'b0, 1'b1);
    cyc();
    idle();
    @(negedge clk);
    chk("t5_evt3_clr", bus.event_cnt_o[15:12], 4'd0);
    chk("t5_stall_cyc_clr", bus.stall_cycle_cnt_o, 4'd0);
    cyc();

    // Reset during recovery.
    set_in(4'b0010, 2'b0, 32'h0, 32'h0, 3'd0, 3'd0, 2'b0, 1'b0);
    cyc();
    set_in(4'b0, 2'b01, 32'h500, 32'h0, 3'd3, 3'd0, 2'b01, 1'b0);
    cyc();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_pre_recovering", bus.recovering_o, 1'b1);
    chk("t6_pre_evt1", bus.event_cnt_o[7:4], 4'd1);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_recovering", bus.recovering_o, 1'b0);
    chk("t6_stall", bus.stall_o, 4'b0);
    chk("t6_flush", bus.flush_o, 4'b0);
    chk("t6_evt", bus.event_cnt_o, 16'h0);
    chk("t6_stall_cyc", bus.stall_cycle_cnt_o, 4'd0);
    cyc();
    cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
